// File: rtl/reorder_buffer_param_pkg.sv
// Shared reorder-buffer types: pointer typedef, run/trap state and pointer helpers.
// Helpers take the index width so one package serves every DEPTH up to 256.
package reorder_buffer_param_pkg;

  localparam int MAX_PW = 9;

  typedef logic [MAX_PW-1:0] ptr_t;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } rob_state_t;

  function automatic ptr_t ptr_mask(input int unsigned iw);
    return ptr_t'((1 << (iw + 1)) - 1);
  endfunction

  // {flip, idx} addition: the carry out of idx lands in flip.
  function automatic ptr_t ptr_adv(input ptr_t p, input ptr_t n, input int unsigned iw);
    return (p + n) & ptr_mask(iw);
  endfunction

  function automatic ptr_t ptr_age(input ptr_t p, input ptr_t base, input int unsigned iw);
    return (p - base) & ptr_mask(iw);
  endfunction

  function automatic logic ptr_age_lt(input ptr_t a, input ptr_t b, input ptr_t base,
                                      input int unsigned iw);
    return ptr_age(a, base, iw) < ptr_age(b, base, iw);
  endfunction

endpackage

// File: rtl/reorder_buffer_param_commit_sel.sv
// Commit selector: contiguous in-order mask from the head, commit count and lane pointers.
// Purely combinational.
module rob_commit_sel
  import reorder_buffer_param_pkg::*;
#(
  parameter int IW    = 6,
  parameter int CMT_W = 4
) (
  input  logic [IW:0]             head,
  input  logic [IW:0]             count,
  input  logic                    en,
  input  logic [CMT_W-1:0]        lane_done,
  input  logic [CMT_W-1:0]        lane_exc,
  output logic [CMT_W-1:0]        mask,
  output logic [IW:0]             cnt,
  output logic [CMT_W*(IW+1)-1:0] lane_ptr
);

  localparam int PW = IW + 1;

  for (genvar k = 0; k < CMT_W; k++) begin : g_ptr
    assign lane_ptr[k*PW +: PW] = PW'(ptr_adv(ptr_t'(head), ptr_t'(k), IW));
  end

  always_comb begin
    logic ok;
    ok   = en;
    mask = '0;
    cnt  = '0;
    for (int k = 0; k < CMT_W; k++) begin
      ok      = ok && (PW'(k) < count) && lane_done[k] && !lane_exc[k];
      mask[k] = ok;
      if (ok) cnt = cnt + PW'(1);
    end
  end

endmodule

// File: rtl/reorder_buffer_param.sv
// Parameterised reorder buffer: multi-lane allocate, out-of-order writeback, in-order commit,
// exception trap with flush-on-ack and mispredict rollback of the tail.
module reorder_buffer_param
  import reorder_buffer_param_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int ENQ_W = 4,
  parameter int CMT_W = 4,
  parameter int WB_W  = 6,
  parameter int PLD_W = 64,
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      o_enq_rdy,
  input  logic [ENQ_W-1:0]          i_enq_vld,
  input  logic [ENQ_W-1:0]          i_enq_done,
  input  logic [ENQ_W*PLD_W-1:0]    i_enq_pld,
  output logic [ENQ_W*(IW+1)-1:0]   o_enq_ptr,
  input  logic [WB_W-1:0]           i_wb_vld,
  input  logic [WB_W*IW-1:0]        i_wb_idx,
  input  logic [WB_W-1:0]           i_wb_exc,
  input  logic                      i_rb_vld,
  input  logic [IW:0]               i_rb_ptr,
  input  logic                      i_stall,
  output logic [CMT_W-1:0]          o_cmt_vld,
  output logic [CMT_W*PLD_W-1:0]    o_cmt_pld,
  output logic [CMT_W*(IW+1)-1:0]   o_cmt_ptr,
  output logic                      o_trap_vld,
  output logic [IW:0]               o_trap_ptr,
  output logic [PLD_W-1:0]          o_trap_pld,
  input  logic                      i_trap_ack,
  output logic [IW:0]               o_count
);

  localparam int PW = IW + 1;

  logic [IW:0]      head, tail, count, enq_num, cmt_cnt;
  logic [IW+1:0]    free;
  rob_state_t       state;
  logic [DEPTH-1:0] done, exc;
  logic [PLD_W-1:0] mem [DEPTH];

  logic [CMT_W-1:0] lane_done, lane_exc;
  logic [IW-1:0]    enq_idx [ENQ_W];
  logic [IW-1:0]    cmt_idx [CMT_W];
  logic [WB_W-1:0]  wb_occ;
  logic             enq_fire, trap_hit, cmt_en;
  logic [IW-1:0]    head_idx;

  assign count    = tail - head;
  assign o_count  = count;
  assign head_idx = head[IW-1:0];
  assign free     = (IW+2)'(DEPTH) - (IW+2)'(count);

  assign o_enq_rdy = !rst && (state == RUN) && !i_rb_vld && (free >= (IW+2)'(ENQ_W));
  assign enq_fire  = o_enq_rdy && (|i_enq_vld);

  always_comb begin
    enq_num = '0;
    for (int k = 0; k < ENQ_W; k++)
      if (i_enq_vld[k]) enq_num = enq_num + PW'(1);
  end

  for (genvar k = 0; k < ENQ_W; k++) begin : g_enq
    assign o_enq_ptr[k*PW +: PW] = PW'(ptr_adv(ptr_t'(tail), ptr_t'(k), IW));
    assign enq_idx[k]            = o_enq_ptr[k*PW +: IW];
  end

  // Occupancy is the index distance from head being below count.
  for (genvar j = 0; j < WB_W; j++) begin : g_wb
    logic [IW-1:0] off;
    assign off       = i_wb_idx[j*IW +: IW] - head_idx;
    assign wb_occ[j] = ({1'b0, off} < count);
  end

  assign cmt_en = !rst && (state == RUN) && !i_stall;

  for (genvar k = 0; k < CMT_W; k++) begin : g_cmt
    assign cmt_idx[k]               = o_cmt_ptr[k*PW +: IW];
    assign lane_done[k]             = done[cmt_idx[k]];
    assign lane_exc[k]              = exc[cmt_idx[k]];
    assign o_cmt_pld[k*PLD_W +: PLD_W] = mem[cmt_idx[k]];
  end

  rob_commit_sel #(
    .IW    (IW),
    .CMT_W (CMT_W)
  ) u_commit_sel (
    .head      (head),
    .count     (count),
    .en        (cmt_en),
    .lane_done (lane_done),
    .lane_exc  (lane_exc),
    .mask      (o_cmt_vld),
    .cnt       (cmt_cnt),
    .lane_ptr  (o_cmt_ptr)
  );

  assign trap_hit   = (state == RUN) && (count != '0) && done[head_idx] && exc[head_idx];
  assign o_trap_vld = !rst && (state == TRAP);
  assign o_trap_ptr = head;
  assign o_trap_pld = mem[head_idx];

  always_ff @(posedge clk) begin
    if (enq_fire)
      for (int k = 0; k < ENQ_W; k++)
        if (i_enq_vld[k]) mem[enq_idx[k]] <= i_enq_pld[k*PLD_W +: PLD_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      done  <= '0;
      exc   <= '0;
      state <= RUN;
    end else begin
      // Bits are only ever set here, so colliding writebacks OR naturally.
      for (int j = 0; j < WB_W; j++) begin
        if (i_wb_vld[j] && wb_occ[j]) begin
          done[i_wb_idx[j*IW +: IW]] <= 1'b1;
          if (i_wb_exc[j]) exc[i_wb_idx[j*IW +: IW]] <= 1'b1;
        end
      end
      if (enq_fire) begin
        for (int k = 0; k < ENQ_W; k++) begin
          if (i_enq_vld[k]) begin
            done[enq_idx[k]] <= i_enq_done[k];
            exc[enq_idx[k]]  <= 1'b0;
          end
        end
      end

      head <= head + cmt_cnt;

      if (state == TRAP) begin
        if (i_trap_ack) begin
          tail  <= head;
          state <= RUN;
        end
      end else begin
        if (i_rb_vld)
          tail <= PW'(ptr_adv(ptr_t'(i_rb_ptr), ptr_t'(1), IW));
        else if (enq_fire)
          tail <= PW'(ptr_adv(ptr_t'(tail), ptr_t'(enq_num), IW));
        if (trap_hit) state <= TRAP;
      end
    end
  end

  a_rb_in_window: assert property (@(posedge clk) disable iff (rst)
    (i_rb_vld && state == RUN) |-> ptr_age_lt(ptr_t'(i_rb_ptr), ptr_t'(tail), ptr_t'(head), IW));

endmodule

// File: tb/tb_reorder_buffer_param.sv
// Directed bench for reorder_buffer_param at default parameters (DEPTH 64, 4/4/6 lanes).
module tb_reorder_buffer_param;

  logic         clk = 1'b0;
  logic         rst;
  logic         o_enq_rdy;
  logic [3:0]   i_enq_vld, i_enq_done;
  logic [255:0] i_enq_pld;
  logic [27:0]  o_enq_ptr;
  logic [5:0]   i_wb_vld, i_wb_exc;
  logic [35:0]  i_wb_idx;
  logic         i_rb_vld;
  logic [6:0]   i_rb_ptr;
  logic         i_stall;
  logic [3:0]   o_cmt_vld;
  logic [255:0] o_cmt_pld;
  logic [27:0]  o_cmt_ptr;
  logic         o_trap_vld;
  logic [6:0]   o_trap_ptr;
  logic [63:0]  o_trap_pld;
  logic         i_trap_ack;
  logic [6:0]   o_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reorder_buffer_param dut (
    .clk(clk), .rst(rst), .o_enq_rdy(o_enq_rdy), .i_enq_vld(i_enq_vld),
    .i_enq_done(i_enq_done), .i_enq_pld(i_enq_pld), .o_enq_ptr(o_enq_ptr),
    .i_wb_vld(i_wb_vld), .i_wb_idx(i_wb_idx), .i_wb_exc(i_wb_exc),
    .i_rb_vld(i_rb_vld), .i_rb_ptr(i_rb_ptr), .i_stall(i_stall),
    .o_cmt_vld(o_cmt_vld), .o_cmt_pld(o_cmt_pld), .o_cmt_ptr(o_cmt_ptr),
    .o_trap_vld(o_trap_vld), .o_trap_ptr(o_trap_ptr), .o_trap_pld(o_trap_pld),
    .i_trap_ack(i_trap_ack), .o_count(o_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_enq_vld = '0; i_enq_done = '0; i_enq_pld = '0;
    i_wb_vld = '0; i_wb_idx = '0; i_wb_exc = '0;
    i_rb_vld = 1'b0; i_rb_ptr = '0; i_stall = 1'b0; i_trap_ack = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic enq(input int n, input logic [3:0] dn, input logic [63:0] base);
    i_enq_vld  = 4'((1 << n) - 1);
    i_enq_done = dn;
    for (int k = 0; k < 4; k++) i_enq_pld[k*64 +: 64] = base + 64'(k);
    tick();
    i_enq_vld = '0;
  endtask

  task automatic wb_set(input int slot, input int idx, input logic e);
    i_wb_vld[slot]         = 1'b1;
    i_wb_idx[slot*6 +: 6]  = 6'(idx);
    i_wb_exc[slot]         = e;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick(); #1;
    tests++;
    if (o_enq_rdy !== 1'b0 || o_cmt_vld !== 4'h0 || o_trap_vld !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: rdy=%b cmt=%h trap=%b, want 0/0/0", o_enq_rdy, o_cmt_vld, o_trap_vld);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (o_enq_rdy !== 1'b1 || o_count !== 7'd0 || o_enq_ptr[6:0] !== 7'd0 || o_enq_ptr[27:21] !== 7'd3) begin
      fails++;
      $display("FAIL post_reset: rdy=%b count=%0d p0=%0d p3=%0d, want 1/0/0/3",
               o_enq_rdy, o_count, o_enq_ptr[6:0], o_enq_ptr[27:21]);
    end
  endtask

  task automatic test_commit_all();
    enq(4, 4'b0000, 64'd100);
    tests++;
    if (o_count !== 7'd4 || o_cmt_vld !== 4'h0) begin
      fails++;
      $display("FAIL enq4_count: count=%0d cmt=%h, want 4/0", o_count, o_cmt_vld);
    end
    for (int i = 0; i < 4; i++) wb_set(i, i, 1'b0);
    tick();
    i_wb_vld = '0;
    tests++;
    if (o_cmt_vld !== 4'hf || o_cmt_pld[128 +: 64] !== 64'd102 || o_cmt_ptr[27:21] !== 7'd3) begin
      fails++;
      $display("FAIL commit4: cmt=%h pld2=%0d ptr3=%0d, want f/102/3",
               o_cmt_vld, o_cmt_pld[128 +: 64], o_cmt_ptr[27:21]);
    end
    tick();
    tests++;
    if (o_count !== 7'd0 || o_cmt_vld !== 4'h0) begin
      fails++;
      $display("FAIL commit4_drain: count=%0d cmt=%h, want 0/0", o_count, o_cmt_vld);
    end
  endtask

  task automatic test_partial();
    // Entries 4..7 follow the previous test.
    enq(4, 4'b0000, 64'd200);
    wb_set(0, 4, 1'b0); wb_set(1, 6, 1'b0); wb_set(2, 7, 1'b0);
    tick();
    i_wb_vld = '0;
    tests++;
    if (o_cmt_vld !== 4'b0001 || o_cmt_ptr[6:0] !== 7'd4) begin
      fails++;
      $display("FAIL partial_gap: cmt=%b ptr0=%0d, want 0001/4", o_cmt_vld, o_cmt_ptr[6:0]);
    end
    tick();
    tests++;
    if (o_count !== 7'd3 || o_cmt_vld !== 4'h0) begin
      fails++;
      $display("FAIL partial_blocked: count=%0d cmt=%h, want 3/0", o_count, o_cmt_vld);
    end
    wb_set(0, 5, 1'b0);
    tick();
    i_wb_vld = '0;
    tests++;
    if (o_cmt_vld !== 4'b0111 || o_cmt_ptr[6:0] !== 7'd5 || o_cmt_pld[0 +: 64] !== 64'd201) begin
      fails++;
      $display("FAIL partial_fill: cmt=%b ptr0=%0d pld0=%0d, want 0111/5/201",
               o_cmt_vld, o_cmt_ptr[6:0], o_cmt_pld[0 +: 64]);
    end
    tick();
    tests++;
    if (o_count !== 7'd0) begin
      fails++;
      $display("FAIL partial_drain: count=%0d, want 0", o_count);
    end
  endtask

  task automatic test_trap();
    do_reset();
    enq(4, 4'b0000, 64'd300);
    wb_set(0, 0, 1'b0); wb_set(1, 1, 1'b1);
    tick();
    i_wb_vld = '0; i_wb_exc = '0;
    tests++;
    if (o_cmt_vld !== 4'b0001 || o_trap_vld !== 1'b0) begin
      fails++;
      $display("FAIL trap_commit0: cmt=%b trap=%b, want 0001/0", o_cmt_vld, o_trap_vld);
    end
    tick(); tick();
    tests++;
    if (o_trap_vld !== 1'b1 || o_trap_ptr !== 7'd1 || o_trap_pld !== 64'd301 ||
        o_enq_rdy !== 1'b0 || o_cmt_vld !== 4'h0) begin
      fails++;
      $display("FAIL trap_held: trap=%b ptr=%0d pld=%0d rdy=%b cmt=%h, want 1/1/301/0/0",
               o_trap_vld, o_trap_ptr, o_trap_pld, o_enq_rdy, o_cmt_vld);
    end
    i_trap_ack = 1'b1;
    tick();
    i_trap_ack = 1'b0;
    tests++;
    if (o_trap_vld !== 1'b0 || o_count !== 7'd0 || o_enq_ptr[6:0] !== 7'd1 || o_enq_rdy !== 1'b1) begin
      fails++;
      $display("FAIL trap_ack: trap=%b count=%0d p0=%0d rdy=%b, want 0/0/1/1",
               o_trap_vld, o_count, o_enq_ptr[6:0], o_enq_rdy);
    end
  endtask

  task automatic test_full();
    do_reset();
    i_stall = 1'b1;
    for (int c = 0; c < 16; c++) enq(4, 4'b1111, 64'(c * 4));
    tests++;
    if (o_enq_rdy !== 1'b0 || o_count !== 7'd64 || o_enq_ptr[6:0] !== 7'd64 || o_cmt_vld !== 4'h0) begin
      fails++;
      $display("FAIL full: rdy=%b count=%0d p0=%0d cmt=%h, want 0/64/64/0",
               o_enq_rdy, o_count, o_enq_ptr[6:0], o_cmt_vld);
    end
    i_stall = 1'b0;
    #1;
    tests++;
    if (o_cmt_vld !== 4'hf || o_cmt_ptr[6:0] !== 7'd0) begin
      fails++;
      $display("FAIL full_unstall: cmt=%h ptr0=%0d, want f/0", o_cmt_vld, o_cmt_ptr[6:0]);
    end
    tick();
    tests++;
    if (o_count !== 7'd60 || o_enq_rdy !== 1'b1 || o_enq_ptr[27:21] !== 7'd67) begin
      fails++;
      $display("FAIL full_release: count=%0d rdy=%b p3=%0d, want 60/1/67", o_count, o_enq_rdy, o_enq_ptr[27:21]);
    end
  endtask

  task automatic test_rollback();
    do_reset();
    enq(4, 4'b0000, 64'd400);
    enq(4, 4'b0000, 64'd404);
    enq(2, 4'b0000, 64'd408);
    tests++;
    if (o_count !== 7'd10) begin
      fails++;
      $display("FAIL rb_prefill: count=%0d, want 10", o_count);
    end
    i_rb_vld = 1'b1; i_rb_ptr = 7'd4; i_enq_vld = 4'hf;
    #1;
    tests++;
    if (o_enq_rdy !== 1'b0) begin
      fails++;
      $display("FAIL rb_rdy: rdy=%b, want 0", o_enq_rdy);
    end
    tick();
    i_rb_vld = 1'b0; i_enq_vld = '0;
    tests++;
    if (o_count !== 7'd5 || o_enq_ptr[6:0] !== 7'd5) begin
      fails++;
      $display("FAIL rb_tail: count=%0d p0=%0d, want 5/5", o_count, o_enq_ptr[6:0]);
    end
    wb_set(0, 7, 1'b0);
    tick();
    i_wb_vld = '0;
    tests++;
    if (o_count !== 7'd5 || o_cmt_vld !== 4'h0) begin
      fails++;
      $display("FAIL rb_wb_ignored: count=%0d cmt=%h, want 5/0", o_count, o_cmt_vld);
    end
    for (int i = 0; i < 5; i++) wb_set(i, i, 1'b0);
    tick();
    i_wb_vld = '0;
    tests++;
    if (o_cmt_vld !== 4'hf) begin
      fails++;
      $display("FAIL rb_commit4: cmt=%h, want f", o_cmt_vld);
    end
    tick();
    tests++;
    if (o_cmt_vld !== 4'b0001 || o_cmt_ptr[6:0] !== 7'd4 || o_cmt_pld[0 +: 64] !== 64'd404) begin
      fails++;
      $display("FAIL rb_commit_last: cmt=%b ptr0=%0d pld0=%0d, want 0001/4/404",
               o_cmt_vld, o_cmt_ptr[6:0], o_cmt_pld[0 +: 64]);
    end
    tick();
    tests++;
    if (o_count !== 7'd0) begin
      fails++;
      $display("FAIL rb_drain: count=%0d, want 0", o_count);
    end
  endtask

  task automatic test_reset_in_trap();
    do_reset();
    enq(2, 4'b0000, 64'd500);
    wb_set(0, 0, 1'b1);
    tick();
    i_wb_vld = '0; i_wb_exc = '0;
    tick();
    tests++;
    if (o_trap_vld !== 1'b1 || o_trap_ptr !== 7'd0) begin
      fails++;
      $display("FAIL rit_trap: trap=%b ptr=%0d, want 1/0", o_trap_vld, o_trap_ptr);
    end
    rst = 1'b1;
    tick();
    tests++;
    if (o_trap_vld !== 1'b0 || o_count !== 7'd0 || o_cmt_vld !== 4'h0 ||
        o_enq_rdy !== 1'b0 || o_enq_ptr[6:0] !== 7'd0) begin
      fails++;
      $display("FAIL rit_reset: trap=%b count=%0d cmt=%h rdy=%b p0=%0d, want 0/0/0/0/0",
               o_trap_vld, o_count, o_cmt_vld, o_enq_rdy, o_enq_ptr[6:0]);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (o_enq_rdy !== 1'b1 || o_trap_vld !== 1'b0) begin
      fails++;
      $display("FAIL rit_release: rdy=%b trap=%b, want 1/0", o_enq_rdy, o_trap_vld);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_commit_all();
    test_partial();
    test_trap();
    test_full();
    test_rollback();
    test_reset_in_trap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
